control_sequencer: RTL and testbench

//  Control unit that sits directly downstream of the 4-phase timing counter.

---
 rtl/control_sequencer.sv | 148 ++++++++++++++
 tb/tb_control_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute control unit for a 4-phase accumulator machine
// Optional CU_CARRY_EN adds registered carry flag output e (ADD/INC carry, CLA clears).
module control_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [3:0]        t,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              sc_clr,
  output logic [DATA_W-1:0] acc,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
`ifdef CU_CARRY_EN
  output logic              e,
`endif
  output logic              t_err
);

  typedef enum logic [1:0] {PH_FETCH, PH_LOAD, PH_DECODE, PH_EXEC} phase_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_CLA = 4'h5;
  localparam logic [3:0] OP_INC = 4'h6;
  localparam logic [3:0] OP_HLT = 4'h7;

  phase_t            phase, phase_nxt;
  logic [DATA_W-1:0] ir, ir_nxt, acc_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              halted_nxt, t_err_nxt;
  logic              carry_we, carry_val;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              one_hot, in_phase;

  assign opcode   = ir[DATA_W-1 -: 4];
  assign operand  = ir[ADDR_W-1:0];
  assign one_hot  = (t != 4'b0000) && ((t & (t - 4'd1)) == 4'b0000);
  // A one-hot phase that is not the one we expect executes nothing and resyncs the counter.
  assign in_phase = (t == (4'b0001 << phase));

  always_comb begin
    phase_nxt  = phase;
    ir_nxt     = ir;
    pc_nxt     = pc;
    acc_nxt    = acc;
    halted_nxt = halted;
    t_err_nxt  = t_err;
    carry_we   = 1'b0;
    carry_val  = 1'b0;
    mem_addr   = pc;
    mem_rd     = 1'b0;
    sc_clr     = 1'b0;
    if (clr || halted) begin
      sc_clr = 1'b1;
    end else if (!one_hot) begin
      t_err_nxt = 1'b1;
      sc_clr    = 1'b1;
      phase_nxt = PH_FETCH;
    end else if (!in_phase) begin
      sc_clr    = 1'b1;
      phase_nxt = PH_FETCH;
    end else begin
      case (phase)
        PH_FETCH: begin
          mem_rd    = 1'b1;
          phase_nxt = PH_LOAD;
        end
        PH_LOAD: begin
          ir_nxt    = mem_rdata;
          pc_nxt    = pc + 1'b1;
          phase_nxt = PH_DECODE;
        end
        PH_DECODE: begin
          phase_nxt = PH_FETCH;
          sc_clr    = 1'b1;
          case (opcode)
            OP_LDA, OP_ADD, OP_AND: begin
              mem_addr  = operand;
              mem_rd    = 1'b1;
              sc_clr    = 1'b0;
              phase_nxt = PH_EXEC;
            end
            OP_JMP: pc_nxt = operand;
            OP_CLA: begin
              acc_nxt  = '0;
              carry_we = 1'b1;
            end
            OP_INC: begin
              {carry_val, acc_nxt} = {1'b0, acc} + (DATA_W+1)'(1);
              carry_we = 1'b1;
            end
            OP_HLT: halted_nxt = 1'b1;
            default: ;
          endcase
        end
        PH_EXEC: begin
          phase_nxt = PH_FETCH;
          case (opcode)
            OP_LDA: acc_nxt = mem_rdata;
            OP_ADD: begin
              {carry_val, acc_nxt} = {1'b0, acc} + {1'b0, mem_rdata};
              carry_we = 1'b1;
            end
            OP_AND: acc_nxt = acc & mem_rdata;
            default: ;
          endcase
        end
        default: phase_nxt = PH_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      phase  <= PH_FETCH;
      ir     <= '0;
      pc     <= '0;
      acc    <= '0;
      halted <= 1'b0;
      t_err  <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      ir     <= ir_nxt;
      pc     <= pc_nxt;
      acc    <= acc_nxt;
      halted <= halted_nxt;
      t_err  <= t_err_nxt;
    end
  end

`ifdef CU_CARRY_EN
  always_ff @(posedge clk) begin
    if (clr)           e <= 1'b0;
    else if (carry_we) e <= carry_val;
  end
`else
  logic unused_carry;
  assign unused_carry = carry_we ^ carry_val;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed bench for control_sequencer with per-cycle reference model
module tb_control_sequencer;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic [3:0]    t;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, sc_clr, halted, t_err;
  logic [DW-1:0] acc;
  logic [AW-1:0] pc;
`ifdef CU_CARRY_EN
  logic          e;
`endif

  logic [DW-1:0] mem [16];
  int            cnt = 0;
  bit            ovr = 1'b0;
  logic [3:0]    ovr_t = 4'b0000;
  int            total = 0, bad = 0;

  control_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .clr(clr), .t(t), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .sc_clr(sc_clr),
    .acc(acc), .pc(pc), .halted(halted),
`ifdef CU_CARRY_EN
    .e(e),
`endif
    .t_err(t_err)
  );

  always #5 clk = ~clk;

  // external 4-phase counter and synchronous memory
  always_comb t = ovr ? ovr_t : 4'(1 << cnt);
  always @(posedge clk) cnt <= sc_clr ? 0 : (cnt + 1) % 4;
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // reference model: expected phase index plus architectural state
  bit            mv = 1'b0;
  int            ph, op, sum;
  int            m_pc, m_acc, m_ir;
  bit            m_halt, m_terr, m_e;

  function automatic bool_ok();
    return (!clr && !m_halt && $countones(t) == 1 && t == 4'(1 << ph));
  endfunction

  always @(posedge clk) begin
    if (clr) begin
      mv = 1; ph = 0; m_pc = 0; m_acc = 0; m_ir = 0; m_halt = 0; m_terr = 0; m_e = 0;
    end else if (mv && !m_halt) begin
      if ($countones(t) != 1) begin
        m_terr = 1; ph = 0;
      end else if (t != 4'(1 << ph)) begin
        ph = 0;
      end else begin
        op = m_ir / 16;
        case (ph)
          0: ph = 1;
          1: begin m_ir = int'(mem_rdata); m_pc = (m_pc + 1) % 16; ph = 2; end
          2: begin
            ph = 0;
            if (op >= 1 && op <= 3) ph = 3;
            else if (op == 4) m_pc = m_ir % 16;
            else if (op == 5) begin m_acc = 0; m_e = 0; end
            else if (op == 6) begin sum = m_acc + 1; m_e = (sum > 255); m_acc = sum % 256; end
            else if (op == 7) m_halt = 1;
          end
          default: begin
            ph = 0;
            if (op == 1) m_acc = int'(mem_rdata);
            else if (op == 2) begin
              sum = m_acc + int'(mem_rdata); m_e = (sum > 255); m_acc = sum % 256;
            end else m_acc = m_acc & int'(mem_rdata);
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    int  ea;
    bit  erd, esc;
    if (mv) begin
      ea = m_pc; erd = 0; esc = 1;
      if (bool_ok()) begin
        esc = 0;
        if (ph == 0) erd = 1;
        else if (ph == 2) begin
          if (m_ir / 16 >= 1 && m_ir / 16 <= 3) begin ea = m_ir % 16; erd = 1; end
          else esc = 1;
        end
      end
      chk("mem_addr", 32'(mem_addr), 32'(ea));
      chk("mem_rd", 32'(mem_rd), 32'(erd));
      chk("sc_clr", 32'(sc_clr), 32'(esc));
      chk("acc", 32'(acc), 32'(m_acc));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("halted", 32'(halted), 32'(m_halt));
      chk("t_err", 32'(t_err), 32'(m_terr));
`ifdef CU_CARRY_EN
      chk("e", 32'(e), 32'(m_e));
`endif
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 8'h15; mem[1] = 8'h26; mem[2] = 8'h4A;
    mem[5] = 8'h3C; mem[6] = 8'hD0; mem[10] = 8'h70;

    cyc(2);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_acc", 32'(acc), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_t_err", 32'(t_err), 32'h0);
    chk("rst_sc_clr", 32'(sc_clr), 32'h1);
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    clr = 1'b0;

    cyc(8);
    chk("lda_add_acc", 32'(acc), 32'h0C);
    chk("lda_add_pc", 32'(pc), 32'h2);
`ifdef CU_CARRY_EN
    chk("add_carry", 32'(e), 32'h1);
`endif

    cyc(2);
    chk("jmp_t2_sc_clr", 32'(sc_clr), 32'h1);
    cyc(1);
    chk("jmp_t", 32'(t), 32'h1);
    chk("jmp_mem_addr", 32'(mem_addr), 32'hA);
    chk("jmp_pc", 32'(pc), 32'hA);

    cyc(3);
    chk("hlt_halted", 32'(halted), 32'h1);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("hlt_sc_clr", 32'(sc_clr), 32'h1);
      chk("hlt_mem_rd", 32'(mem_rd), 32'h0);
    end
    chk("hlt_pc", 32'(pc), 32'hB);
    clr = 1'b1;
    cyc(1);
    chk("clr_halted", 32'(halted), 32'h0);
    chk("clr_pc", 32'(pc), 32'h0);

    clr = 1'b0;
    cyc(1);
    ovr = 1'b1; ovr_t = 4'b0110;
    #1;
    chk("terr_sc_clr", 32'(sc_clr), 32'h1);
    cyc(1);
    ovr = 1'b0;
    chk("terr_set", 32'(t_err), 32'h1);
    chk("terr_pc", 32'(pc), 32'h0);
    chk("terr_acc", 32'(acc), 32'h0);
    cyc(8);
    chk("terr_resume_acc", 32'(acc), 32'h0C);
    chk("terr_sticky", 32'(t_err), 32'h1);

    clr = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 8'h60; mem[1] = 8'h28; mem[2] = 8'h4F; mem[8] = 8'hFE;
    cyc(1);
    chk("clr_t_err", 32'(t_err), 32'h0);
    clr = 1'b0;
    cyc(13);
    chk("wrap_pc", 32'(pc), 32'h0);
    chk("wrap_acc", 32'(acc), 32'hFF);
    cyc(3);
    chk("inc_wrap_acc", 32'(acc), 32'h00);
    chk("inc_wrap_pc", 32'(pc), 32'h1);
`ifdef CU_CARRY_EN
    chk("inc_carry", 32'(e), 32'h1);
`endif

    ovr = 1'b1; ovr_t = 4'b1000;
    cyc(1);
    ovr = 1'b0;
    chk("oop_acc", 32'(acc), 32'h00);
    chk("oop_pc", 32'(pc), 32'h1);
    cyc(4);
    chk("after_oop_acc", 32'(acc), 32'hFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
